// File: rtl/game_state_mux.sv
// Game sequencer (IDLE/PLAY/WIN/LOSE) and final registered pixel selector for the
// racing display; state is mirrored to the display path only on frame boundaries.
module game_state_mux #(
  parameter int HOLD_FRAMES = 180,
  parameter int VIDEO_DLY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        win_flag,
  input  logic        crash_flag,
  input  logic [11:0] track_pix,
  input  logic [11:0] title_pix,
  input  logic [11:0] you_win_pix,
  input  logic [11:0] game_over_pix,
  output logic        game_run,
  output logic        game_reset,
  output logic [1:0]  state,
  output logic [11:0] vga_pix
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int VD = (VIDEO_DLY > 0) ? VIDEO_DLY : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  state_t          st;
  state_t          st_next;
  state_t          disp_st;
  logic            btn_q;
  logic            guard;
  logic            start_edge;
  logic            restart;
  logic            hold_done;
  logic [HW-1:0]   hold_cnt;
  logic [VD-1:0]   vid_sr;
  logic            vid_d;
  logic [11:0]     pix_sel;

  assign start_edge = btn_start & ~btn_q;
  assign hold_done  = (hold_cnt == HOLD_MAX);
  assign state      = st;

  always_comb begin
    st_next = st;
    restart = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start_edge) begin
          st_next = S_PLAY;
          restart = 1'b1;
        end
      end
      S_PLAY: begin
        // guard masks flags left over from the previous game until a frame has passed
        if (!guard) begin
          if (win_flag)        st_next = S_WIN;
          else if (crash_flag) st_next = S_LOSE;
        end
      end
      default: begin
        if (hold_done && start_edge) begin
          st_next = S_PLAY;
          restart = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    pix_sel = track_pix;
    unique case (disp_st)
      S_IDLE:  pix_sel = title_pix;
      S_PLAY:  pix_sel = track_pix;
      S_WIN:   pix_sel = (you_win_pix != 12'h000) ? you_win_pix : track_pix;
      default: pix_sel = (game_over_pix != 12'h000) ? game_over_pix : track_pix;
    endcase
  end

  assign vid_d = (VIDEO_DLY == 0) ? video_on : vid_sr[VD-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      disp_st    <= S_IDLE;
      game_run   <= 1'b0;
      game_reset <= 1'b0;
      vga_pix    <= 12'h000;
      hold_cnt   <= '0;
      btn_q      <= 1'b0;
      guard      <= 1'b0;
      vid_sr     <= '0;
    end else begin
      st         <= st_next;
      btn_q      <= btn_start;
      game_reset <= restart;
      game_run   <= (st_next == S_PLAY);

      if (restart)
        guard <= 1'b1;
      else if (st == S_PLAY && frame_tick)
        guard <= 1'b0;

      // Held at zero during PLAY so it is already cleared on entry to WIN/LOSE
      if (st == S_PLAY)
        hold_cnt <= '0;
      else if ((st == S_WIN || st == S_LOSE) && frame_tick && !hold_done)
        hold_cnt <= hold_cnt + 1'b1;

      if (frame_tick)
        disp_st <= st;

      vid_sr[0] <= video_on;
      for (int i = 1; i < VD; i++)
        vid_sr[i] <= vid_sr[i-1];

      vga_pix <= vid_d ? pix_sel : 12'h000;
    end
  end

endmodule

// File: tb/tb_game_state_mux.sv
// Bench for game_state_mux: scripted vector table, hand sequences for the overlay
// and reset corners, then random stimulus against a cycle-level reference model.
module tb_game_state_mux;

  localparam int HOLD = 3;
  localparam int VDLY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_start = 1'b0;
  logic        win_flag = 1'b0;
  logic        crash_flag = 1'b0;
  logic [11:0] track_pix = 12'h0F0;
  logic [11:0] title_pix = 12'hABC;
  logic [11:0] you_win_pix = 12'h000;
  logic [11:0] game_over_pix = 12'h000;
  logic        game_run;
  logic        game_reset;
  logic [1:0]  state;
  logic [11:0] vga_pix;

  game_state_mux #(.HOLD_FRAMES(HOLD), .VIDEO_DLY(VDLY)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
    .btn_start(btn_start), .win_flag(win_flag), .crash_flag(crash_flag),
    .track_pix(track_pix), .title_pix(title_pix), .you_win_pix(you_win_pix),
    .game_over_pix(game_over_pix), .game_run(game_run), .game_reset(game_reset),
    .state(state), .vga_pix(vga_pix)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: game phase as an integer, video history as a queue
  int   m_st = 0, m_disp = 0, m_hold = 0;
  bit   m_guard = 0, m_btn = 0, m_run = 0, m_rst = 0;
  logic [11:0] m_pix = 12'h000;
  bit   vq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] sel_pix(input int d);
    case (d)
      0:       return title_pix;
      1:       return track_pix;
      2:       return (you_win_pix != 0) ? you_win_pix : track_pix;
      default: return (game_over_pix != 0) ? game_over_pix : track_pix;
    endcase
  endfunction

  task automatic model_edge();
    int ost;
    bit se;
    if (reset) begin
      m_st = 0; m_disp = 0; m_hold = 0; m_guard = 0; m_btn = 0;
      m_run = 0; m_rst = 0; m_pix = 12'h000;
      vq.delete();
      repeat (VDLY) vq.push_back(1'b0);
      return;
    end
    ost = m_st;
    se  = btn_start && !m_btn;
    m_pix = vq[0] ? sel_pix(m_disp) : 12'h000;
    void'(vq.pop_front());
    vq.push_back(video_on);
    m_rst = 0;
    if (frame_tick) m_disp = ost;
    case (ost)
      0: begin
        if (se) begin m_st = 1; m_rst = 1; m_guard = 1; end
      end
      1: begin
        if (m_guard) begin
          if (frame_tick) m_guard = 0;
        end else if (win_flag) begin
          m_st = 2; m_hold = 0;
        end else if (crash_flag) begin
          m_st = 3; m_hold = 0;
        end
      end
      default: begin
        if (m_hold == HOLD && se) begin
          m_st = 1; m_rst = 1; m_guard = 1;
        end else if (frame_tick && m_hold < HOLD) begin
          m_hold++;
        end
      end
    endcase
    m_run = (m_st == 1);
    m_btn = btn_start;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", int'(state), m_st);
    chk("game_run", int'(game_run), int'(m_run));
    chk("game_reset", int'(game_reset), int'(m_rst));
    chk("vga_pix", int'(vga_pix), int'(m_pix));
  endtask

  task automatic drive(input bit b, input bit ft, input bit w, input bit c);
    btn_start = b; frame_tick = ft; win_flag = w; crash_flag = c;
    step();
  endtask

  typedef struct packed {
    logic       btn, ft, win, crash;
    logic [1:0] st;
    logic       run, rst;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // btn ft win crash | state run reset
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1};

    // reset and idle title screen for three short frames
    reset = 1'b1;
    step();
    reset = 1'b0;
    video_on = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 8; c++)
        drive(1'b0, (c == 7), 1'b0, 1'b0);
    chk("idle_vga", int'(vga_pix), 32'hABC);
    chk("idle_state", int'(state), 0);
    chk("idle_run", int'(game_run), 0);

    // scripted game: start, guard, win priority, hold window, lose, restart
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].btn, vecs[i].ft, vecs[i].win, vecs[i].crash);
      chk("tbl_state", int'(state), int'(vecs[i].st));
      chk("tbl_run", int'(game_run), int'(vecs[i].run));
      chk("tbl_reset", int'(game_reset), int'(vecs[i].rst));
    end

    // reach LOSE and let the display follow it
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    game_over_pix = 12'h000; track_pix = 12'h0F0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lose_transparent", int'(vga_pix), 32'h0F0);
    game_over_pix = 12'hF00;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lose_overlay", int'(vga_pix), 32'hF00);
    video_on = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("video_dly_still_on", int'(vga_pix), 32'hF00);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("video_off", int'(vga_pix), 0);

    // back to PLAY, then reset in the middle of the game
    video_on = 1'b1;
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("replay_state", int'(state), 1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", int'(state), 0);
    chk("rst_run", int'(game_run), 0);
    chk("rst_vga", int'(vga_pix), 0);
    chk("rst_no_pulse", int'(game_reset), 0);
    reset = 1'b0;

    // randomized play against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset         = ($urandom_range(0, 399) == 0);
      video_on      = ($urandom_range(0, 9) != 0);
      track_pix     = 12'($urandom);
      title_pix     = 12'($urandom);
      you_win_pix   = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      game_over_pix = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      drive(($urandom_range(0, 2) == 0), (cyc % 12 == 11),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
